// File: rtl/i2s_tx_pkg.sv
// Shared constants and types for the I2S transmitter: frame geometry and
// slot-position helpers used by the timing generator and the data path.
package i2s_tx_pkg;

  localparam int unsigned SLOT_BITS      = 32;
  localparam int unsigned FRAME_BITS     = 64;
  localparam int unsigned DEF_DATA_W     = 24;
  localparam int unsigned DEF_BCLK_HALF  = 4;

  localparam int unsigned BIT_CNT_W = $clog2(FRAME_BITS);
  localparam int unsigned SLOT_POS_W = $clog2(SLOT_BITS);

  typedef logic [BIT_CNT_W-1:0]  bit_cnt_t;
  typedef logic [SLOT_POS_W-1:0] slot_pos_t;

  // Data occupies positions 1..last_pos; position 0 is the I2S one-bit delay.
  function automatic logic is_data_pos(slot_pos_t pos, slot_pos_t last_pos);
    return (pos != '0) && (pos <= last_pos);
  endfunction

endpackage

// File: rtl/i2s_timing.sv
// BCLK divider and frame bit counter. Produces a strobe on each BCLK falling
// edge together with the bit index the serial outputs move to on that edge.
module i2s_timing
  import i2s_tx_pkg::*;
#(
  parameter int unsigned BCLK_HALF = DEF_BCLK_HALF
) (
  input  logic      clk,
  input  logic      rst_n,
  output logic      o_bclk,
  output logic      o_lrclk,
  output logic      o_fall,
  output logic      o_frame_start,
  output slot_pos_t o_pos
);

  localparam int unsigned DivW = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic            bclk_q, bclk_d;
  logic            lrclk_q, lrclk_d;
  bit_cnt_t        bit_cnt_q, bit_cnt_d;

  logic     div_tc;
  logic     fall;
  bit_cnt_t bit_next;

  always_comb begin
    div_tc    = (div_cnt_q == DivW'(BCLK_HALF - 1));
    fall      = div_tc & bclk_q;
    bit_next  = bit_cnt_q + bit_cnt_t'(1);
    div_cnt_d = div_tc ? '0 : div_cnt_q + DivW'(1);
    bclk_d    = bclk_q ^ div_tc;
    bit_cnt_d = fall ? bit_next : bit_cnt_q;
    lrclk_d   = fall ? bit_next[BIT_CNT_W-1] : lrclk_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
      lrclk_q   <= 1'b1;
      bit_cnt_q <= '1;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
      lrclk_q   <= lrclk_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign o_bclk        = bclk_q;
  assign o_lrclk       = lrclk_q;
  assign o_fall        = fall;
  assign o_frame_start = fall && (bit_next == '0);
  assign o_pos         = bit_next[SLOT_POS_W-1:0];

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: holds one mixed sample per frame and sends it on both
// the left and right slots, flagging dropped and repeated samples.
module i2s_tx
  import i2s_tx_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned BCLK_HALF = DEF_BCLK_HALF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_bclk,
  output logic              o_lrclk,
  output logic              o_sdata,
  output logic              o_overrun,
  output logic              o_underrun
);

  localparam slot_pos_t LastDataPos = slot_pos_t'(DATA_W);

  logic      fall;
  logic      frame_start;
  slot_pos_t pos;

  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              hold_full_q, hold_full_d;
  logic              sdata_q, sdata_d;
  logic              overrun_q, overrun_d;
  logic              underrun_q, underrun_d;
  logic              consume;

  i2s_timing #(
    .BCLK_HALF(BCLK_HALF)
  ) u_timing (
    .clk          (clk),
    .rst_n        (rst_n),
    .o_bclk       (o_bclk),
    .o_lrclk      (o_lrclk),
    .o_fall       (fall),
    .o_frame_start(frame_start),
    .o_pos        (pos)
  );

  always_comb begin
    hold_d      = hold_q;
    last_d      = last_q;
    shreg_d     = shreg_q;
    hold_full_d = hold_full_q;
    sdata_d     = sdata_q;
    overrun_d   = 1'b0;
    underrun_d  = 1'b0;
    consume     = frame_start & hold_full_q;

    // Rotating rather than shifting leaves shreg intact after the left slot,
    // so the right slot replays the same word without a reload.
    if (fall) begin
      if (is_data_pos(pos, LastDataPos)) begin
        sdata_d = shreg_q[DATA_W-1];
        shreg_d = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
      end else begin
        sdata_d = 1'b0;
      end
    end

    if (frame_start) begin
      if (hold_full_q) begin
        shreg_d     = hold_q;
        last_d      = hold_q;
        hold_full_d = 1'b0;
      end else begin
        shreg_d    = last_q;
        underrun_d = 1'b1;
      end
    end

    if (i_valid) begin
      hold_d      = i_data;
      hold_full_d = 1'b1;
      overrun_d   = hold_full_q & ~consume;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q      <= '0;
      last_q      <= '0;
      shreg_q     <= '0;
      hold_full_q <= 1'b0;
      sdata_q     <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      last_q      <= last_d;
      shreg_q     <= shreg_d;
      hold_full_q <= hold_full_d;
      sdata_q     <= sdata_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign o_sdata    = sdata_q;
  assign o_overrun  = overrun_q;
  assign o_underrun = underrun_q;

endmodule
